// File: rtl/booth_wallace_csa16_if.sv
// Operand/row handshake bundle between the multiplier front-end and its neighbours.
// The slave modport is the multiplier side.
interface booth_wallace_csa16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_tc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_cin;

  modport slave (
    input  in_valid, in_a, in_b, in_tc, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_cin
  );

  modport master (
    output in_valid, in_a, in_b, in_tc, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_cin
  );
endinterface

// File: rtl/booth_wallace_csa16.sv
// Two-stage 16x16 radix-4 Booth / Wallace front-end: reduces the partial products to
// sum + carry rows plus a carry-in for the downstream 32-bit carry-lookahead adder.
module booth_wallace_csa16 (
  input  logic                        clk,
  input  logic                        rst_n,
  booth_wallace_csa16_if.slave        bus
);

  function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    csa = {((x & y) | (x & z) | (y & z)) << 1, x ^ y ^ z};
  endfunction

  logic              s1_v, s2_v;
  logic              s1_load, s2_load, accept;
  logic [3:0][31:0]  s1_rows;
  logic              s1_cin;
  logic [31:0]       out_a_q, out_b_q;
  logic              out_cin_q;

  logic [16:0]       a_ext;
  logic [18:0]       b_win;
  logic [2:0]        grp;
  logic [18:0]       mag, pp19;
  logic [8:0]        neg;
  logic [8:0][31:0]  pp;
  logic [31:0]       corr;

  // Booth recoding and partial-product generation; b_win carries the implicit bit -1.
  always_comb begin
    a_ext = {bus.in_tc & bus.in_a[15], bus.in_a};
    b_win = {{2{bus.in_tc & bus.in_b[15]}}, bus.in_b, 1'b0};
    grp   = '0;
    mag   = '0;
    pp19  = '0;
    neg   = '0;
    pp    = '0;
    corr  = '0;
    for (int i = 0; i < 9; i++) begin
      grp = b_win[2*i +: 3];
      case (grp)
        3'b001, 3'b010: mag = {{2{a_ext[16]}}, a_ext};
        3'b101, 3'b110: begin mag = {{2{a_ext[16]}}, a_ext}; neg[i] = 1'b1; end
        3'b011:         mag = {a_ext[16], a_ext, 1'b0};
        3'b100:         begin mag = {a_ext[16], a_ext, 1'b0}; neg[i] = 1'b1; end
        default:        mag = '0;
      endcase
      pp19  = neg[i] ? ~mag : mag;
      pp[i] = {{13{pp19[18]}}, pp19} << (2*i);
    end
    // Digit 0's +1 goes out on out_cin; the rest ride in the correction row.
    for (int i = 1; i < 9; i++) begin
      corr = corr | (32'(neg[i]) << (2*i));
    end
  end

  logic [31:0] l1_s0, l1_c0, l1_s1, l1_c1, l1_s2, l1_c2;
  logic [31:0] l2_s0, l2_c0, l2_s1, l2_c1;
  logic [31:0] l3_s0, l3_c0;
  logic [31:0] l4_s0, l4_c0, l5_s0, l5_c0;

  // Stage-1 tree: 10 rows -> 7 -> 5 -> 4.
  assign {l1_c0, l1_s0} = csa(pp[0], pp[1], pp[2]);
  assign {l1_c1, l1_s1} = csa(pp[3], pp[4], pp[5]);
  assign {l1_c2, l1_s2} = csa(pp[6], pp[7], pp[8]);
  assign {l2_c0, l2_s0} = csa(l1_s0, l1_c0, l1_s1);
  assign {l2_c1, l2_s1} = csa(l1_c1, l1_s2, l1_c2);
  assign {l3_c0, l3_s0} = csa(l2_s0, l2_c0, corr);

  // Stage-2: a 4:2 built from two chained 3:2 counters.
  assign {l4_c0, l4_s0} = csa(s1_rows[0], s1_rows[1], s1_rows[2]);
  assign {l5_c0, l5_s0} = csa(l4_s0, l4_c0, s1_rows[3]);

  assign s2_load      = !s2_v || bus.out_ready;
  assign s1_load      = !s1_v || s2_load;
  assign bus.in_ready = rst_n && !bus.flush && s1_load;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (bus.flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s1_load) s1_v <= accept;
      if (s2_load) s2_v <= s1_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rows   <= '0;
      s1_cin    <= 1'b0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_cin_q <= 1'b0;
    end else begin
      if (accept) begin
        s1_rows <= {l2_c1, l2_s1, l3_c0, l3_s0};
        s1_cin  <= neg[0];
      end
      if (s2_load && s1_v && !bus.flush) begin
        out_a_q   <= l5_s0;
        out_b_q   <= l5_c0;
        out_cin_q <= s1_cin;
      end
    end
  end

  assign bus.out_valid = s2_v;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_cin   = out_cin_q;

endmodule
